// File: rtl/instruction_byte_collector_pkg.sv
// i8088_decode_pkg: shared constants and types for the instruction byte
// collector. Segment/REP encodings, prefix byte values, collector states,
// the assembled instruction record and a ModRM displacement-size helper.
package i8088_decode_pkg;

  // Segment override encoding (matches indirectSeg)
  localparam logic [2:0] SEG_ES   = 3'd0;
  localparam logic [2:0] SEG_CS   = 3'd1;
  localparam logic [2:0] SEG_SS   = 3'd2;
  localparam logic [2:0] SEG_DS   = 3'd3;
  localparam logic [2:0] SEG_NONE = 3'd4;

  // Prefix bytes
  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  // REP encodings
  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NE   = 2'b10;
  localparam logic [1:0] REP_E    = 2'b11;

  typedef enum logic [2:0] {
    S_FIRST,
    S_MODRM,
    S_DISP,
    S_IMM,
    S_DONE
  } state_t;

  // Assembled instruction record, exactly as presented to the execution unit
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic        has_modrm;
    logic [15:0] disp;
    logic [31:0] imm;
    logic [2:0]  seg;
    logic [1:0]  rep;
    logic        lock;
    logic [3:0]  len;
    logic [19:0] addr;
  } instr_rec_t;

  // Idle record: everything zero except "no segment override"
  function automatic instr_rec_t rec_clear();
    instr_rec_t r;
    r     = '0;
    r.seg = SEG_NONE;
    return r;
  endfunction

  // Displacement bytes implied by a ModRM byte
  function automatic logic [1:0] disp_bytes(input logic [7:0] m);
    logic [1:0] n;
    case (m[7:6])
      2'b00:   n = (m[2:0] == 3'b110) ? 2'd2 : 2'd0;  // direct address
      2'b01:   n = 2'd1;
      2'b10:   n = 2'd2;
      default: n = 2'd0;                             // register operand
    endcase
    return n;
  endfunction

endpackage

// File: rtl/instruction_byte_collector_opcode_length_rom.sv
// opcode_length_rom: combinational operand-shape table for 8088 opcodes.
// Ports:
//   opcode      in  8  opcode byte (prefixes never reach this table)
//   needs_modrm out 1  a ModRM byte follows
//   imm_bytes   out 3  immediate/offset bytes (0/1/2/4)
//   test_group  out 1  F6/F7: immediate exists only when ModRM.reg==000
// 8088 aliases (60-6F as Jcc, C0/C1/C8/C9 as RET forms) are treated like the
// opcodes they execute as, so their byte counts match the real CPU.
module opcode_length_rom (
  input  logic [7:0] opcode,
  output logic       needs_modrm,
  output logic [2:0] imm_bytes,
  output logic       test_group
);

  always_comb begin
    needs_modrm = 1'b0;
    imm_bytes   = 3'd0;
    test_group  = 1'b0;
    if (opcode[7:6] == 2'b00) begin
      // ALU block: x0-x3/x8-xB are r/m forms, x4/xC AL,imm8, x5/xD AX,imm16
      if (!opcode[2])                   needs_modrm = 1'b1;
      else if (opcode[2:0] == 3'b100)   imm_bytes   = 3'd1;
      else if (opcode[2:0] == 3'b101)   imm_bytes   = 3'd2;
    end else begin
      casez (opcode)
        8'b0110_????,
        8'b0111_????: imm_bytes = 3'd1;                        // Jcc rel8
        8'h80, 8'h82, 8'h83: begin needs_modrm = 1'b1; imm_bytes = 3'd1; end
        8'h81:               begin needs_modrm = 1'b1; imm_bytes = 3'd2; end
        8'b1000_01??,
        8'b1000_1???: needs_modrm = 1'b1;                      // TEST..POP r/m
        8'h9A:        imm_bytes = 3'd4;                        // CALL far
        8'b1010_00??: imm_bytes = 3'd2;                        // MOV moffs
        8'hA8:        imm_bytes = 3'd1;
        8'hA9:        imm_bytes = 3'd2;
        8'b1011_0???: imm_bytes = 3'd1;                        // MOV r8,imm8
        8'b1011_1???: imm_bytes = 3'd2;                        // MOV r16,imm16
        8'hC0, 8'hC2, 8'hC8, 8'hCA: imm_bytes = 3'd2;          // RET imm16
        8'hC4, 8'hC5: needs_modrm = 1'b1;                      // LES/LDS
        8'hC6:        begin needs_modrm = 1'b1; imm_bytes = 3'd1; end
        8'hC7:        begin needs_modrm = 1'b1; imm_bytes = 3'd2; end
        8'hCD:        imm_bytes = 3'd1;                        // INT n
        8'b1101_00??: needs_modrm = 1'b1;                      // shifts
        8'hD4, 8'hD5: imm_bytes = 3'd1;                        // AAM/AAD
        8'b1101_1???: needs_modrm = 1'b1;                      // ESC
        8'b1110_0???: imm_bytes = 3'd1;                        // LOOP/JCXZ/IN/OUT
        8'hE8, 8'hE9: imm_bytes = 3'd2;
        8'hEA:        imm_bytes = 3'd4;                        // JMP far
        8'hEB:        imm_bytes = 3'd1;
        8'hF6: begin needs_modrm = 1'b1; imm_bytes = 3'd1; test_group = 1'b1; end
        8'hF7: begin needs_modrm = 1'b1; imm_bytes = 3'd2; test_group = 1'b1; end
        8'hFE, 8'hFF: needs_modrm = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_byte_collector.sv
// instruction_byte_collector: pops bytes from the prefetch queue top with
// single-cycle advanceTop pulses and assembles one 8088 instruction
// (prefixes, opcode, ModRM, displacement, immediate) per pass, then offers it
// to the execution unit over instr_valid/instr_ready.
// Ports:
//   CLKx4, RESET (sync, active-high)
//   prefetchTop/prefetchTopLinearAddress/prefetchEmpty  queue top view
//   suspending   bus unit suspending/flushing, blocks pops
//   advanceTop   pop pulse (one cycle)
//   flush        abandon the instruction in progress
//   instr_valid/instr_ready  record handshake
//   opcode, modrm, has_modrm, disp, imm, seg_override, rep, lock,
//   instr_len, instr_addr    assembled record (registered)
module instruction_byte_collector
  import i8088_decode_pkg::*;
#(
  parameter int ADV_GAP = 1,
  parameter int MAX_LEN = 15
) (
  input  logic        CLKx4,
  input  logic        RESET,
  input  logic [7:0]  prefetchTop,
  input  logic [19:0] prefetchTopLinearAddress,
  input  logic        prefetchEmpty,
  input  logic        suspending,
  output logic        advanceTop,
  input  logic        flush,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic        has_modrm,
  output logic [15:0] disp,
  output logic [31:0] imm,
  output logic [2:0]  seg_override,
  output logic [1:0]  rep,
  output logic        lock,
  output logic [3:0]  instr_len,
  output logic [19:0] instr_addr
);

  localparam int GW = (ADV_GAP < 1) ? 1 : $clog2(ADV_GAP + 1);

  state_t     r_state;
  logic [GW-1:0] r_gap;
  logic       r_adv;
  logic       r_valid;
  instr_rec_t r_rec;
  logic [2:0] r_imm_cnt;   // immediate bytes still owed by this opcode
  logic [1:0] r_disp_cnt;
  logic [1:0] r_idx;       // byte index inside the current disp/imm field
  logic       r_test_grp;

  logic       w_rom_modrm;
  logic [2:0] w_rom_imm;
  logic       w_rom_tg;
  logic       w_pop;
  logic [1:0] w_disp_n;
  logic [2:0] w_modrm_imm;
  logic [3:0] w_len_next;
  logic       w_last_disp;
  logic       w_last_imm;

  // Only the opcode byte ever needs the table, and it is looked up in the
  // very cycle it sits at the queue top.
  opcode_length_rom u_rom (
    .opcode      (prefetchTop),
    .needs_modrm (w_rom_modrm),
    .imm_bytes   (w_rom_imm),
    .test_group  (w_rom_tg)
  );

  // Flush blocks the pop outright so no byte of the abandoned stream is eaten.
  assign w_pop = (r_state != S_DONE) && (r_gap == '0) && !prefetchEmpty &&
                 !suspending && !flush;

  assign w_disp_n    = disp_bytes(prefetchTop);
  // TEST r/m,imm is the only F6/F7 member carrying an immediate
  assign w_modrm_imm = (r_test_grp && (prefetchTop[5:3] != 3'b000)) ? 3'd0 : r_imm_cnt;
  assign w_len_next  = (r_rec.len >= 4'(MAX_LEN)) ? r_rec.len : r_rec.len + 4'd1;
  assign w_last_disp = ((r_idx + 2'd1) == r_disp_cnt);
  assign w_last_imm  = (({1'b0, r_idx} + 3'd1) == r_imm_cnt);

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      r_state    <= S_FIRST;
      r_gap      <= '0;
      r_adv      <= 1'b0;
      r_valid    <= 1'b0;
      r_rec      <= rec_clear();
      r_imm_cnt  <= 3'd0;
      r_disp_cnt <= 2'd0;
      r_idx      <= 2'd0;
      r_test_grp <= 1'b0;
    end else begin
      r_adv <= w_pop;
      // Gap counter keeps running regardless of state, flush or handshake
      if (w_pop)              r_gap <= GW'(ADV_GAP);
      else if (r_gap != '0)   r_gap <= r_gap - 1'b1;

      if (flush) begin
        r_state    <= S_FIRST;
        r_valid    <= 1'b0;
        r_rec      <= rec_clear();
        r_imm_cnt  <= 3'd0;
        r_disp_cnt <= 2'd0;
        r_idx      <= 2'd0;
        r_test_grp <= 1'b0;
      end else if (r_state == S_DONE) begin
        if (r_valid && instr_ready) begin
          r_state <= S_FIRST;
          r_valid <= 1'b0;
          r_rec   <= rec_clear();
        end
      end else if (w_pop) begin
        r_rec.len <= w_len_next;
        case (r_state)
          S_FIRST: begin
            // len never returns to zero once counting, so this marks byte one
            if (r_rec.len == 4'd0) r_rec.addr <= prefetchTopLinearAddress;
            case (prefetchTop)
              PFX_ES, PFX_CS, PFX_SS, PFX_DS:
                r_rec.seg <= {1'b0, prefetchTop[4:3]};
              PFX_LOCK:  r_rec.lock <= 1'b1;
              PFX_REPNE: r_rec.rep  <= REP_NE;
              PFX_REP:   r_rec.rep  <= REP_E;
              default: begin
                r_rec.opcode <= prefetchTop;
                r_imm_cnt    <= w_rom_imm;
                r_test_grp   <= w_rom_tg;
                r_idx        <= 2'd0;
                if (w_rom_modrm)            r_state <= S_MODRM;
                else if (w_rom_imm != 3'd0) r_state <= S_IMM;
                else begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
                end
              end
            endcase
          end
          S_MODRM: begin
            r_rec.modrm     <= prefetchTop;
            r_rec.has_modrm <= 1'b1;
            r_disp_cnt      <= w_disp_n;
            r_imm_cnt       <= w_modrm_imm;
            r_idx           <= 2'd0;
            if (w_disp_n != 2'd0)         r_state <= S_DISP;
            else if (w_modrm_imm != 3'd0) r_state <= S_IMM;
            else begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end
          end
          S_DISP: begin
            if (r_disp_cnt == 2'd1)  r_rec.disp       <= {{8{prefetchTop[7]}}, prefetchTop};
            else if (r_idx == 2'd0)  r_rec.disp[7:0]  <= prefetchTop;
            else                     r_rec.disp[15:8] <= prefetchTop;
            if (w_last_disp) begin
              r_idx <= 2'd0;
              if (r_imm_cnt != 3'd0) r_state <= S_IMM;
              else begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
          S_IMM: begin
            r_rec.imm[{r_idx, 3'b000} +: 8] <= prefetchTop;
            if (w_last_imm) begin
              r_idx   <= 2'd0;
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign advanceTop   = r_adv;
  assign instr_valid  = r_valid;
  assign opcode       = r_rec.opcode;
  assign modrm        = r_rec.modrm;
  assign has_modrm    = r_rec.has_modrm;
  assign disp         = r_rec.disp;
  assign imm          = r_rec.imm;
  assign seg_override = r_rec.seg;
  assign rep          = r_rec.rep;
  assign lock         = r_rec.lock;
  assign instr_len    = r_rec.len;
  assign instr_addr   = r_rec.addr;

endmodule

// File: tb/tb_instruction_byte_collector.sv
// Scoreboard bench: stimulus pushes bytes into a queue model and the
// expected record into exp_q; a negedge monitor models the prefetch queue,
// pops on advanceTop and checks every accepted record against exp_q.
module tb_instruction_byte_collector;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  mr;
    logic        hm;
    logic [15:0] d;
    logic [31:0] im;
    logic [2:0]  sg;
    logic [1:0]  rp;
    logic        lk;
    logic [3:0]  ln;
    logic [19:0] ad;
  } rec_t;

  localparam rec_t CLR = {8'h0, 8'h0, 1'b0, 16'h0, 32'h0, 3'd4, 2'b00, 1'b0, 4'h0, 20'h0};

  logic        CLKx4 = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  prefetchTop = 8'h00;
  logic [19:0] prefetchTopLinearAddress = 20'h0;
  logic        prefetchEmpty = 1'b1;
  logic        suspending = 1'b0;
  logic        flush = 1'b0;
  logic        instr_ready = 1'b1;
  logic        advanceTop, instr_valid, has_modrm, lock;
  logic [7:0]  opcode, modrm;
  logic [15:0] disp;
  logic [31:0] imm;
  logic [2:0]  seg_override;
  logic [1:0]  rep;
  logic [3:0]  instr_len;
  logic [19:0] instr_addr;

  instruction_byte_collector dut (
    .CLKx4(CLKx4), .RESET(RESET),
    .prefetchTop(prefetchTop), .prefetchTopLinearAddress(prefetchTopLinearAddress),
    .prefetchEmpty(prefetchEmpty), .suspending(suspending), .advanceTop(advanceTop),
    .flush(flush), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .opcode(opcode), .modrm(modrm), .has_modrm(has_modrm), .disp(disp), .imm(imm),
    .seg_override(seg_override), .rep(rep), .lock(lock),
    .instr_len(instr_len), .instr_addr(instr_addr)
  );

  always #5 CLKx4 = ~CLKx4;

  logic [7:0]  qb[$];
  logic [19:0] qa[$];
  rec_t        exp_q[$];
  logic [19:0] next_addr = 20'h0F100;
  logic        force_empty = 1'b0;
  int          checks = 0, failures = 0, adv_count = 0;
  logic        prev_adv = 1'b0, prev_valid = 1'b0, last_empty = 1'b1, last_susp = 1'b0;
  logic        chk_clear = 1'b0;
  rec_t        held, act, e;

  function automatic rec_t cur();
    return {opcode, modrm, has_modrm, disp, imm, seg_override, rep, lock, instr_len, instr_addr};
  endfunction

  task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, x);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    qb.push_back(b);
    qa.push_back(next_addr);
    next_addr = next_addr + 20'd1;
  endtask

  // bytes given first-byte-most-significant, n of them
  task automatic feed(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) push_byte(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_rec(input logic [7:0] op, input logic [7:0] mr, input logic hm,
                            input logic [15:0] d, input logic [31:0] im, input logic [2:0] sg,
                            input logic [1:0] rp, input logic lk, input logic [3:0] ln);
    rec_t r;
    r = {op, mr, hm, d, im, sg, rp, lk, ln, next_addr};
    exp_q.push_back(r);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || qb.size() != 0) && n < 2000) begin
      @(posedge CLKx4);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL timeout_%s pending_exp=%0d pending_bytes=%0d", nm, exp_q.size(), qb.size());
      exp_q.delete(); qb.delete(); qa.delete();
    end
    repeat (3) @(posedge CLKx4);
    #1;
  endtask

  task automatic wait_bytes_gone(input string nm);
    int n = 0;
    while (qb.size() != 0 && n < 500) begin
      @(posedge CLKx4);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL timeout_%s bytes_left=%0d", nm, qb.size());
    end
    repeat (3) @(posedge CLKx4);
    #1;
  endtask

  // Queue model + monitor. Inputs only change at posedge+#1 or here, so the
  // values recorded at this negedge are what the following posedge samples.
  always @(negedge CLKx4) begin
    if (!RESET) begin
      act = cur();
      if (chk_clear) begin
        chk_clear = 1'b0;
        chk("post_accept_clear", {instr_valid, act}, {1'b0, CLR});
      end
      if (advanceTop) begin
        adv_count++;
        checks++;
        if (prev_adv || last_empty || last_susp) begin
          failures++;
          $display("FAIL adv_rule got prev_adv=%0b empty=%0b susp=%0b exp all 0",
                   prev_adv, last_empty, last_susp);
        end
        if (qb.size() != 0) begin
          void'(qb.pop_front());
          void'(qa.pop_front());
        end else begin
          failures++;
          $display("FAIL pop_on_empty got advanceTop=1 exp 0");
        end
      end
      if (instr_valid) begin
        if (instr_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_instr got=%h exp none", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              failures++;
              $display("FAIL instr_rec got=%h exp=%h", act, e);
            end
          end
          chk_clear = 1'b1;
        end else if (prev_valid) begin
          chk("hold_stable", {advanceTop, act}, {1'b0, held});
        end
        held = act;
      end
    end
    prev_adv   = advanceTop;
    prev_valid = instr_valid;
    prefetchEmpty            = force_empty || (qb.size() == 0);
    prefetchTop              = (qb.size() != 0) ? qb[0] : 8'h00;
    prefetchTopLinearAddress = (qa.size() != 0) ? qa[0] : 20'h0;
    last_empty = prefetchEmpty;
    last_susp  = suspending;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, cyc, susp_left;
    logic done_susp;
    repeat (3) @(posedge CLKx4);
    #1;
    chk("reset_rec", {instr_valid, advanceTop, cur()}, {1'b0, 1'b0, CLR});
    RESET = 1'b0;
    @(posedge CLKx4); #1;

    // T1: CS: MOV AX,[BP-2]
    a0 = adv_count;
    expect_rec(8'h8B, 8'h46, 1'b1, 16'hFFFE, 32'h0, 3'd1, 2'b00, 1'b0, 4'd4);
    feed({8'h2E, 8'h8B, 8'h46, 8'hFE}, 4);
    wait_idle("t1");
    chk("t1_adv_pulses", adv_count - a0, 4);

    // T2: JMP far F000:0100
    a0 = adv_count;
    expect_rec(8'hEA, 8'h00, 1'b0, 16'h0, 32'hF000_0100, 3'd4, 2'b00, 1'b0, 4'd5);
    feed({8'hEA, 8'h00, 8'h01, 8'h00, 8'hF0}, 5);
    wait_idle("t2");
    chk("t2_adv_pulses", adv_count - a0, 5);

    // T3: TEST AX,1234 then NEG AX (group F7, reg!=0 -> no immediate)
    expect_rec(8'hF7, 8'hC0, 1'b1, 16'h0, 32'h1234, 3'd4, 2'b00, 1'b0, 4'd4);
    feed({8'hF7, 8'hC0, 8'h34, 8'h12}, 4);
    expect_rec(8'hF7, 8'hD8, 1'b1, 16'h0, 32'h0, 3'd4, 2'b00, 1'b0, 4'd2);
    feed({8'hF7, 8'hD8}, 2);
    wait_idle("t3");

    // Displacement / immediate shapes
    expect_rec(8'h8B, 8'h86, 1'b1, 16'h1234, 32'h0, 3'd4, 2'b00, 1'b0, 4'd4);
    feed({8'h8B, 8'h86, 8'h34, 8'h12}, 4);
    expect_rec(8'h8B, 8'h06, 1'b1, 16'h5678, 32'h0, 3'd4, 2'b00, 1'b0, 4'd4);
    feed({8'h8B, 8'h06, 8'h78, 8'h56}, 4);
    expect_rec(8'h83, 8'h46, 1'b1, 16'hFFFE, 32'h05, 3'd4, 2'b00, 1'b0, 4'd4);
    feed({8'h83, 8'h46, 8'hFE, 8'h05}, 4);
    expect_rec(8'hF6, 8'hC0, 1'b1, 16'h0, 32'h7F, 3'd4, 2'b00, 1'b0, 4'd3);
    feed({8'hF6, 8'hC0, 8'h7F}, 3);
    wait_idle("shapes");

    // Prefix handling: REP+LOCK; REPNE with two overrides, last wins
    expect_rec(8'hA4, 8'h00, 1'b0, 16'h0, 32'h0, 3'd4, 2'b11, 1'b1, 4'd3);
    feed({8'hF3, 8'hF0, 8'hA4}, 3);
    expect_rec(8'hAC, 8'h00, 1'b0, 16'h0, 32'h0, 3'd0, 2'b10, 1'b0, 4'd4);
    feed({8'hF2, 8'h3E, 8'h26, 8'hAC}, 4);
    wait_idle("prefix");

    // Length saturation: 16 prefixes + NOP = 17 bytes, len stays 15
    expect_rec(8'h90, 8'h00, 1'b0, 16'h0, 32'h0, 3'd0, 2'b00, 1'b0, 4'd15);
    for (int i = 0; i < 15; i++) push_byte(8'h2E);
    push_byte(8'h26);
    push_byte(8'h90);
    wait_idle("sat");

    // T4: stalls between every byte plus a 10-cycle suspend at the ModRM
    expect_rec(8'h8B, 8'h46, 1'b1, 16'hFFFE, 32'h0, 3'd1, 2'b00, 1'b0, 4'd4);
    feed({8'h2E, 8'h8B, 8'h46, 8'hFE}, 4);
    cyc = 0; susp_left = 0; done_susp = 1'b0;
    while (exp_q.size() != 0 && cyc < 600) begin
      @(posedge CLKx4); #1;
      force_empty = ((cyc % 4) != 0);
      if (!done_susp && qb.size() == 2) begin
        done_susp = 1'b1;
        susp_left = 10;
      end
      suspending = (susp_left > 0);
      if (susp_left > 0) susp_left--;
      cyc++;
    end
    force_empty = 1'b0;
    suspending  = 1'b0;
    chk("t4_suspend_hit", {31'h0, done_susp}, 1);
    wait_idle("t4");

    // T5: flush after opcode+ModRM of ADD BX,imm16 (with CS prefix)
    feed({8'h2E, 8'h81, 8'hC3}, 3);
    wait_bytes_gone("t5_pop");
    flush = 1'b1;
    @(posedge CLKx4); #1;
    flush = 1'b0;
    chk("t5_after_flush", {instr_valid, cur()}, {1'b0, CLR});
    expect_rec(8'h90, 8'h00, 1'b0, 16'h0, 32'h0, 3'd4, 2'b00, 1'b0, 4'd1);
    push_byte(8'h90);
    wait_idle("t5");

    // T6: ready held low for 20 cycles with a byte waiting in the queue
    instr_ready = 1'b0;
    expect_rec(8'hB8, 8'h00, 1'b0, 16'h0, 32'h1234, 3'd4, 2'b00, 1'b0, 4'd3);
    feed({8'hB8, 8'h34, 8'h12}, 3);
    expect_rec(8'h90, 8'h00, 1'b0, 16'h0, 32'h0, 3'd4, 2'b00, 1'b0, 4'd1);
    push_byte(8'h90);
    cyc = 0;
    while (!instr_valid && cyc < 200) begin
      @(posedge CLKx4); #1;
      cyc++;
    end
    chk("t6_valid_rose", {31'h0, instr_valid}, 1);
    repeat (20) @(posedge CLKx4);
    #1;
    chk("t6_no_pop_during_hold", qb.size(), 1);
    instr_ready = 1'b1;
    wait_idle("t6");

    // RESET in the middle of an instruction
    feed({8'h2E, 8'h8B}, 2);
    wait_bytes_gone("rst_pop");
    RESET = 1'b1;
    @(posedge CLKx4); #1;
    RESET = 1'b0;
    chk("mid_reset_rec", {instr_valid, advanceTop, cur()}, {1'b0, 1'b0, CLR});
    expect_rec(8'h90, 8'h00, 1'b0, 16'h0, 32'h0, 3'd4, 2'b00, 1'b0, 4'd1);
    push_byte(8'h90);
    wait_idle("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
